mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory (memory2c-style backend) between the fetch-stage instruction port and the memory-stage data port.
- Registers each winning request onto the memory bus and waits a fixed backend latency. It returns read data with a one-cycle ack pulse.
- Data port has priority; a starvation limit guarantees fetch progress.
- Sequences the backend's dump on halt, then stops granting.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- MEM_LAT, 1, cycles from mem_en cycle to valid mem_rdata (>=1).
- STARVE_LIM, 4, max consecutive data grants while i_req is pending before fetch is forced (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  fetch read request, level, held until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_rdata  out  DW  registered instruction word, valid while i_ack=1.
- d_req  in  1  data request, level, held until d_ack.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle completion pulse to memory stage.
- d_rdata  out  DW  registered load data, valid while d_ack=1.
- halt  in  1  level, request dump and stop.
- halted  out  1  sticky, dump done.
- mem_en  out  1  backend enable.
- mem_wr  out  1  backend write.
- mem_addr  out  AW  backend address.
- mem_wdata  out  DW  backend write data.
- mem_rdata  in  DW  backend read data.
- mem_dump  out  1  backend createdump pulse.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0, including i_rdata, d_rdata and halted.
  - Starve and latency counters 0.
  - Any in-flight transaction is abandoned with no ack.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE, DUMP, HALTED.
- IDLE, arbitration in priority order:
  - halt=1 -> DUMP.
  - Else if d_req=1 and not (i_req=1 and starve==STARVE_LIM) -> grant data.
  - Else if i_req=1 -> grant fetch.
  - Else stay in IDLE.
- On a grant:
  - Latch owner, addr, wr (fetch: wr=0) and wdata; go to ISSUE.
  - halt is checked only in IDLE, so an in-flight transaction always completes.
- ISSUE:
  - mem_en=1, mem_wr/mem_addr/mem_wdata = latched values for exactly this cycle.
  - Load latency counter with MEM_LAT; go to WAIT.
- WAIT:
  - mem_en=0; decrement counter.
  - In the cycle mem_rdata is valid (ISSUE cycle + MEM_LAT), capture it into the owner's rdata register (loads and fetches only) and go to DONE.
- DONE:
  - Owner's ack=1 for one cycle; go to IDLE.
  - d_rdata is unchanged for stores.
  - The non-owner's rdata register is never modified.
- Latency: request first seen in IDLE at cycle t -> ack in cycle t+MEM_LAT+2.
- Requester rule: drop req in the cycle after ack unless issuing a new transaction. A req still high in IDLE after DONE is treated as a new transaction.
- Request inputs are sampled only in IDLE. Changes in any other state are ignored.
- Starve counter:
  - Incremented on a data grant while i_req=1, saturating at STARVE_LIM.
  - Cleared on a fetch grant, or when arbitration occurs with i_req=0.
- Simultaneous i_req and d_req with starve<STARVE_LIM -> data wins.
- DUMP:
  - mem_dump=1 and mem_en=0 for one cycle.
  - Go to HALTED with halted=1.
- HALTED:
  - Terminal until reset. No grants, no acks, requests ignored.
  - halt deasserting has no effect.

Test Plan:
- Reset, then i_req=1, i_addr=0x0010, memory returns 0xABCD (MEM_LAT=1) -> mem_en=1 with mem_addr=0x0010 at cycle t+1; i_ack=1 with i_rdata=0xABCD at cycle t+3; d_ack stays 0.
- d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> one mem_en cycle with mem_wr=1, mem_wdata=0x1234; d_ack at t+3; d_rdata unchanged; read-back of 0x0200 returns 0x1234.
- i_req and d_req both held continuously, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I; no two mem_en cycles closer than MEM_LAT+3 cycles apart.
- MEM_LAT=3 load from 0x0040 -> ack exactly 5 cycles after the request is seen; mem_rdata changes outside the sample cycle do not affect d_rdata.
- halt raised during WAIT of a data load -> load completes with d_ack; then one mem_dump pulse; halted=1; subsequent i_req/d_req get no ack and no mem_en.
- rst driven low during WAIT -> all outputs 0 immediately (asynchronously); no ack after release; the next request is served normally from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of all request, response and memory-bus signals
// around the unified-memory arbiter.
//   slave  modport: the arbiter's view. It takes in fetch and data requests,
//                   halt and backend read data. It drives acks, rdata,
//                   halted and the backend bus.
//   master modport: the view of the requesters and backend (pipeline + memory).
// Ports (per signal): i_req/i_addr -> fetch request, i_ack/i_rdata <- fetch
// completion; d_req/d_wr/d_addr/d_wdata -> data request, d_ack/d_rdata <-
// data completion; halt -> dump request, halted <- dump done; mem_en/mem_wr/
// mem_addr/mem_wdata/mem_dump <- backend controls, mem_rdata -> backend data.
interface mem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          halt;
    logic          halted;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_dump;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, halted,
               mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, halted,
               mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the fetch
// port and the data port. Each winning request is registered onto the memory
// bus for a single cycle. The arbiter then waits MEM_LAT cycles, captures the
// read data and returns a one-cycle ack. The data port has priority, but after
// STARVE_LIM consecutive data grants with fetch pending, fetch is forced
// through. On halt the backend dump is pulsed once and the arbiter stops for
// good until reset.
// Ports: clk (rising edge), rst (async, active-low), bus (mem_arbiter_if.slave).
// Every output is a flop.
module mem_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    logic [2:0]       state_r;
    logic [LAT_W-1:0] lat_r;
    logic [STV_W-1:0] starve_r;
    logic             owner_d_r;   // 1 = data port owns the transaction
    logic             wr_r;
    logic             i_ack_r;
    logic             d_ack_r;
    logic [DW-1:0]    i_rdata_r;
    logic [DW-1:0]    d_rdata_r;
    logic             halted_r;
    logic             mem_en_r;
    logic             mem_wr_r;
    logic [AW-1:0]    mem_addr_r;
    logic [DW-1:0]    mem_wdata_r;
    logic             mem_dump_r;

    logic             grant_d_s;
    logic             grant_i_s;
    logic [STV_W-1:0] starve_nxt_s;

    // Arbitration and starve-counter update, only meaningful in IDLE without halt.
    always_comb begin
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        starve_nxt_s = starve_r;
        if ((state_r == ST_IDLE) && !bus.halt) begin
            // Fetch only wins over a pending data request once it has been
            // passed over STARVE_LIM times in a row.
            if (bus.d_req && !(bus.i_req && (starve_r == STV_MAX))) begin
                grant_d_s = 1'b1;
            end else if (bus.i_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end

            if (!bus.i_req || grant_i_s) begin
                starve_nxt_s = '0;
            end else if (grant_d_s && (starve_r != STV_MAX)) begin
                starve_nxt_s = starve_r + STV_ONE;
            end else begin
                starve_nxt_s = starve_r;
            end
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lat_r       <= '0;
            starve_r    <= '0;
            owner_d_r   <= 1'b0;
            wr_r        <= 1'b0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
            halted_r    <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_dump_r  <= 1'b0;
        end else begin
            // Pulse-type outputs and the bus default low; states below raise them.
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_dump_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    starve_r <= starve_nxt_s;
                    if (bus.halt) begin
                        mem_dump_r <= 1'b1;
                        state_r    <= ST_DUMP;
                    end else if (grant_d_s) begin
                        owner_d_r   <= 1'b1;
                        wr_r        <= bus.d_wr;
                        mem_en_r    <= 1'b1;
                        mem_wr_r    <= bus.d_wr;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_wdata;
                        state_r     <= ST_ISSUE;
                    end else if (grant_i_s) begin
                        owner_d_r   <= 1'b0;
                        wr_r        <= 1'b0;
                        mem_en_r    <= 1'b1;
                        mem_addr_r  <= bus.i_addr;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    lat_r   <= LAT_LOAD;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // lat_r == 1 marks the cycle ISSUE + MEM_LAT, the only
                    // cycle in which mem_rdata is valid.
                    if (lat_r == LAT_ONE) begin
                        lat_r <= '0;
                        if (owner_d_r) begin
                            d_ack_r <= 1'b1;
                            if (!wr_r) begin
                                d_rdata_r <= bus.mem_rdata;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end else begin
                            i_ack_r   <= 1'b1;
                            i_rdata_r <= bus.mem_rdata;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        lat_r <= lat_r - LAT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_DUMP: begin
                    halted_r <= 1'b1;
                    state_r  <= ST_HALTED;
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.halted    = halted_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_dump  = mem_dump_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance A uses MEM_LAT=1
// and instance B uses MEM_LAT=3, and each has its own behavioural
// memory2c-style backend. A table of single transactions is applied in a
// loop. Hand-written sequences then cover starvation, halt/dump and
// asynchronous reset during WAIT.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.DW(DW), .AW(AW)) ifa ();
    mem_arbiter_if #(.DW(DW), .AW(AW)) ifb ();

    mem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    mem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    // Backend models: write on mem_en&mem_wr. Read data is valid only in the
    // cycle ISSUE+MEM_LAT and shows a changing junk value in every other cycle.
    logic [15:0] mem_a [0:4095];
    logic [15:0] mem_b [0:4095];
    logic        pv_a [0:3];
    logic        pv_b [0:3];
    logic [11:0] pa_a [0:3];
    logic [11:0] pa_b [0:3];
    bit          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 4096; k++) begin
                mem_a[k] <= 16'(k) ^ 16'h3C00;
                mem_b[k] <= 16'(k) ^ 16'h3C00;
            end
            mem_a[12'h010] <= 16'hABCD; mem_b[12'h010] <= 16'hABCD;
            mem_a[12'h011] <= 16'h1111; mem_b[12'h011] <= 16'h1111;
            mem_a[12'h040] <= 16'h5A5A; mem_b[12'h040] <= 16'h5A5A;
            mem_a[12'hFFF] <= 16'h8001; mem_b[12'hFFF] <= 16'h8001;
            for (int k = 0; k < 4; k++) begin
                pv_a[k] <= 1'b0; pv_b[k] <= 1'b0;
                pa_a[k] <= 12'h000; pa_b[k] <= 12'h000;
            end
            loaded <= 1'b1;
        end else begin
            if (ifa.mem_en && ifa.mem_wr) mem_a[ifa.mem_addr[11:0]] <= ifa.mem_wdata;
            if (ifb.mem_en && ifb.mem_wr) mem_b[ifb.mem_addr[11:0]] <= ifb.mem_wdata;
            pv_a[0] <= ifa.mem_en && !ifa.mem_wr; pa_a[0] <= ifa.mem_addr[11:0];
            pv_b[0] <= ifb.mem_en && !ifb.mem_wr; pa_b[0] <= ifb.mem_addr[11:0];
            for (int k = 1; k < 4; k++) begin
                pv_a[k] <= pv_a[k-1]; pa_a[k] <= pa_a[k-1];
                pv_b[k] <= pv_b[k-1]; pa_b[k] <= pa_b[k-1];
            end
        end
    end

    assign ifa.mem_rdata = pv_a[0] ? mem_a[pa_a[0]] : (16'hDEAD ^ 16'(cyc));
    assign ifb.mem_rdata = pv_b[2] ? mem_b[pa_b[2]] : (16'hBEEF ^ 16'(cyc * 7));

    typedef struct {
        logic i_ack, d_ack, mem_en, mem_wr, mem_dump, halted;
        logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    } snap_t;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_ird [2];
    logic [15:0] exp_drd [2];
    vec_t        tbl [8];

    function automatic snap_t snap(input bit sel);
        snap_t s;
        if (sel) begin
            s.i_ack = ifb.i_ack; s.d_ack = ifb.d_ack; s.mem_en = ifb.mem_en;
            s.mem_wr = ifb.mem_wr; s.mem_dump = ifb.mem_dump; s.halted = ifb.halted;
            s.i_rdata = ifb.i_rdata; s.d_rdata = ifb.d_rdata;
            s.mem_addr = ifb.mem_addr; s.mem_wdata = ifb.mem_wdata;
        end else begin
            s.i_ack = ifa.i_ack; s.d_ack = ifa.d_ack; s.mem_en = ifa.mem_en;
            s.mem_wr = ifa.mem_wr; s.mem_dump = ifa.mem_dump; s.halted = ifa.halted;
            s.i_rdata = ifa.i_rdata; s.d_rdata = ifa.d_rdata;
            s.mem_addr = ifa.mem_addr; s.mem_wdata = ifa.mem_wdata;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit sel, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic dw, input logic [15:0] da,
                         input logic [15:0] dwd);
        if (sel) begin
            ifb.i_req = ir; ifb.i_addr = ia; ifb.d_req = dr;
            ifb.d_wr = dw; ifb.d_addr = da; ifb.d_wdata = dwd;
        end else begin
            ifa.i_req = ir; ifa.i_addr = ia; ifa.d_req = dr;
            ifa.d_wr = dw; ifa.d_addr = da; ifa.d_wdata = dwd;
        end
    endtask

    task automatic chk_zero(input bit sel, input string tag);
        snap_t s;
        s = snap(sel);
        chk({tag, ".i_ack"},     32'(s.i_ack),     32'd0);
        chk({tag, ".d_ack"},     32'(s.d_ack),     32'd0);
        chk({tag, ".i_rdata"},   32'(s.i_rdata),   32'd0);
        chk({tag, ".d_rdata"},   32'(s.d_rdata),   32'd0);
        chk({tag, ".halted"},    32'(s.halted),    32'd0);
        chk({tag, ".mem_en"},    32'(s.mem_en),    32'd0);
        chk({tag, ".mem_wr"},    32'(s.mem_wr),    32'd0);
        chk({tag, ".mem_addr"},  32'(s.mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(s.mem_wdata), 32'd0);
        chk({tag, ".mem_dump"},  32'(s.mem_dump),  32'd0);
    endtask

    // One complete transaction, entered and left at a negedge with the DUT idle.
    task automatic run_txn(input bit sel, input int lat, input logic is_d, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd);
        snap_t s;
        int    t0;
        int    n_en;
        bit    got;
        if (is_d) drive(sel, 1'b0, 16'h0000, 1'b1, wr, addr, wdata);
        else      drive(sel, 1'b1, addr, 1'b0, 1'b0, 16'h0000, 16'h0000);
        t0 = cyc; n_en = 0; got = 1'b0;
        for (int k = 0; k < lat + 8 && !got; k++) begin
            @(negedge clk);
            s = snap(sel);
            if (s.mem_en) begin
                n_en++;
                chk("issue_cycle", 32'(cyc - t0), 32'd1);
                chk("mem_wr", 32'(s.mem_wr), 32'(wr));
                chk("mem_addr", 32'(s.mem_addr), 32'(addr));
                if (wr) chk("mem_wdata", 32'(s.mem_wdata), 32'(wdata));
            end
            if (s.i_ack || s.d_ack) begin
                got = 1'b1;
                drive(sel, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
                if (!wr) begin
                    if (is_d) exp_drd[sel] = exp_rd;
                    else      exp_ird[sel] = exp_rd;
                end
                chk("ack_owner", 32'({s.i_ack, s.d_ack}), is_d ? 32'd1 : 32'd2);
                chk("latency", 32'(cyc - t0), 32'(lat + 2));
                chk("i_rdata", 32'(s.i_rdata), 32'(exp_ird[sel]));
                chk("d_rdata", 32'(s.d_rdata), 32'(exp_drd[sel]));
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            drive(sel, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        chk("mem_en_count", 32'(n_en), 32'd1);
        @(negedge clk);
        s = snap(sel);
        chk("ack_pulse", 32'({s.i_ack, s.d_ack}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t s;
        int    t0;
        int    last_en;
        int    nacks;
        int    n_dump;
        int    n_ack;
        int    n_en;
        int    n_nh;
        bit    exp_d [10];

        tbl[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, rd: 16'hABCD};
        tbl[1] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0200, wdata: 16'h1234, rd: 16'h0000};
        tbl[2] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h0200, wdata: 16'h0000, rd: 16'h1234};
        tbl[3] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0011, wdata: 16'h0000, rd: 16'h1111};
        tbl[4] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, rd: 16'h5A5A};
        tbl[5] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0040, wdata: 16'hC3C3, rd: 16'h0000};
        tbl[6] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, rd: 16'hC3C3};
        tbl[7] = '{is_d: 1'b1, wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, rd: 16'h8001};
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int k = 0; k < 2; k++) begin exp_ird[k] = 16'h0000; exp_drd[k] = 16'h0000; end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        ifa.halt = 1'b0;
        ifb.halt = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(1'b0, "reset_a");
        chk_zero(1'b1, "reset_b");
        rst = 1'b1;
        @(negedge clk);

        // MEM_LAT=3 instance: ack 5 cycles after the request is seen
        run_txn(1'b1, 3, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A);
        run_txn(1'b1, 3, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD);
        run_txn(1'b1, 3, 1'b1, 1'b1, 16'h0040, 16'h7777, 16'h0000);
        run_txn(1'b1, 3, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h7777);

        // Table of single transactions on the MEM_LAT=1 instance
        for (int v = 0; v < 8; v++) begin
            run_txn(1'b0, 1, tbl[v].is_d, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].rd);
        end

        // Starvation: both requests held, grants must go D,D,D,D,I,D,D,D,D,I
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 16'h0000);
        last_en = -1; nacks = 0;
        for (int k = 0; k < 80 && nacks < 10; k++) begin
            @(negedge clk);
            s = snap(1'b0);
            if (s.mem_en) begin
                if (last_en >= 0) chk("en_spacing_ge4", 32'((cyc - last_en) >= 4), 32'd1);
                last_en = cyc;
            end
            if (s.i_ack || s.d_ack) begin
                chk($sformatf("grant_order[%0d]", nacks), 32'(s.d_ack), 32'(exp_d[nacks]));
                if (s.d_ack) chk("starve_d_rdata", 32'(s.d_rdata), 32'h0000C3C3);
                else         chk("starve_i_rdata", 32'(s.i_rdata), 32'h0000ABCD);
                nacks++;
                if (nacks == 10) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        end
        if (nacks < 10) begin
            chk("starve_timeout", 32'(nacks), 32'd10);
            drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        exp_ird[0] = 16'hABCD;
        exp_drd[0] = 16'hC3C3;
        repeat (2) @(negedge clk);

        // Halt raised during WAIT of a load: load completes, then one dump pulse
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000);
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        ifa.halt = 1'b1;
        @(negedge clk);
        s = snap(1'b0);
        chk("halt_load_d_ack", 32'(s.d_ack), 32'd1);
        chk("halt_load_d_rdata", 32'(s.d_rdata), 32'h00001234);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        n_dump = 0; n_en = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s = snap(1'b0);
            if (s.mem_en) n_en++;
            if (s.mem_dump) begin
                n_dump++;
                chk("dump_cycle", 32'(cyc - t0), 32'd5);
            end
        end
        chk("dump_pulses", 32'(n_dump), 32'd1);
        chk("dump_no_mem_en", 32'(n_en), 32'd0);
        chk("halted_set", 32'(s.halted), 32'd1);

        // Halted: requests ignored, halt release has no effect
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 16'h0000);
        n_ack = 0; n_en = 0; n_nh = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 4) ifa.halt = 1'b0;
            s = snap(1'b0);
            if (s.i_ack || s.d_ack) n_ack++;
            if (s.mem_en || s.mem_dump) n_en++;
            if (!s.halted) n_nh++;
        end
        chk("halted_no_ack", 32'(n_ack), 32'd0);
        chk("halted_no_bus", 32'(n_en), 32'd0);
        chk("halted_sticky", 32'(n_nh), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset out of HALTED, then reset asserted during WAIT
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ird[0] = 16'h0000; exp_drd[0] = 16'h0000;
        exp_ird[1] = 16'h0000; exp_drd[1] = 16'h0000;
        chk_zero(1'b0, "rerst_a");
        @(negedge clk);
        run_txn(1'b0, 1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD);
        run_txn(1'b0, 1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
        @(negedge clk);
        s = snap(1'b0);
        chk("wait_rst_issue_en", 32'(s.mem_en), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk_zero(1'b0, "async_rst");
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        exp_ird[0] = 16'h0000; exp_drd[0] = 16'h0000;
        n_ack = 0; n_en = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s = snap(1'b0);
            if (s.i_ack || s.d_ack) n_ack++;
            if (s.mem_en) n_en++;
        end
        chk("post_rst_no_ack", 32'(n_ack), 32'd0);
        chk("post_rst_no_en", 32'(n_en), 32'd0);
        run_txn(1'b0, 1, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
